// File: rtl/arrow_track_pkg.sv
// Shared DDR game definitions: arrow encoding widths and judge-state codes.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package arrow_track_pkg;

  // Number of distinct arrows, one button per arrow.
  localparam int NUM_ARROWS      = 4;
  // Arrow index is [NUM_ARROWS_BITS:0].
  localparam int NUM_ARROWS_BITS = 1;
  localparam int ARROW_W         = NUM_ARROWS_BITS + 1;

  // Judge FSM encodings, kept as plain constants so older blocks can share them.
  localparam logic [1:0] ST_IDLE   = 2'd0;  // slot 0 empty, presses ignored
  localparam logic [1:0] ST_ARMED  = 2'd1;  // slot 0 holds an arrow awaiting a press
  localparam logic [1:0] ST_JUDGED = 2'd2;  // slot 0 already judged, wait for next shift

endpackage

// File: rtl/arrow_track_btn_edge_detect.sv
// Per-bit rising-edge detector for debounced button levels.
// Latency: press is combinational from btn against the previous-cycle level.
// Backpressure: none; the level register updates every cycle, even when the game is paused.
module btn_edge_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press
);

  logic [W-1:0] btn_q;

  // Remember last cycle's levels; during reset load the live level so a
  // button held through reset is not seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= btn;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/arrow_track.sv
// Scrolling arrow track with press judgement, score and combo counters.
// Latency: beat or press at edge N updates slots, hit/miss, score, combo after edge N.
// Backpressure: none; enable low freezes track, judge state and counters.
module arrow_track
  import arrow_track_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SCORE_W = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  beat,
  input  logic [NUM_ARROWS_BITS:0]              arrow_in,
  input  logic [NUM_ARROWS-1:0]                 btn,
  output logic [DEPTH*(NUM_ARROWS_BITS+1)-1:0]  slot_arrow,
  output logic [DEPTH-1:0]                      slot_valid,
  output logic                                  hit,
  output logic                                  miss,
  output logic [SCORE_W-1:0]                    score,
  output logic [SCORE_W-1:0]                    combo
);

  localparam int TRACK_W = DEPTH * ARROW_W;

  logic [NUM_ARROWS-1:0] press;
  logic                  any_press;
  logic                  shift_en;
  logic [ARROW_W-1:0]    target_arrow;
  logic [NUM_ARROWS-1:0] target_onehot;
  logic                  armed;
  logic                  judge_now;
  logic                  correct;
  logic                  hit_nxt;
  logic                  miss_nxt;
  logic [TRACK_W-1:0]    arrow_shifted;
  logic [DEPTH-1:0]      valid_shifted;
  logic [1:0]            state_q;

  btn_edge_detect #(
    .W (NUM_ARROWS)
  ) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  assign any_press    = |press;
  assign shift_en     = enable & beat;
  assign target_arrow = slot_arrow[ARROW_W-1:0];
  assign armed        = (state_q == ST_ARMED);

  // Button mask that counts as a correct press for the arrow at the target line.
  always_comb begin
    target_onehot = '0;
    target_onehot[target_arrow] = 1'b1;
  end

  // A press while armed is always judged, even when a beat lands in the same
  // cycle: it is scored against the outgoing slot 0 and replaces the
  // unjudged-arrow miss that the shift would otherwise raise.
  assign judge_now = enable & armed & any_press;
  assign correct   = (press == target_onehot);
  assign hit_nxt   = judge_now & correct;
  assign miss_nxt  = enable & armed & (any_press ? ~correct : beat);

  // Track contents after one shift: everything moves toward slot 0 and the
  // generator's new arrow enters at the far end.
  always_comb begin
    arrow_shifted = slot_arrow >> ARROW_W;
    arrow_shifted[(DEPTH-1)*ARROW_W +: ARROW_W] = arrow_in;
    valid_shifted = slot_valid >> 1;
    valid_shifted[DEPTH-1] = 1'b1;
  end

  // Track shift register, advanced once per enabled beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_arrow <= '0;
      slot_valid <= '0;
    end else if (shift_en) begin
      slot_arrow <= arrow_shifted;
      slot_valid <= valid_shifted;
    end
  end

  // Judge FSM: re-arm from the new slot 0 on every shift, otherwise lock after a judged press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (shift_en) begin
      state_q <= valid_shifted[0] ? ST_ARMED : ST_IDLE;
    end else if (judge_now) begin
      state_q <= ST_JUDGED;
    end
  end

  // Feedback pulses, one cycle wide and mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end else begin
      hit  <= hit_nxt;
      miss <= miss_nxt;
    end
  end

  // Saturating score and combo; any miss breaks the combo but keeps the score.
  always_ff @(posedge clk) begin
    if (rst) begin
      score <= '0;
      combo <= '0;
    end else if (hit_nxt) begin
      if (score != {SCORE_W{1'b1}}) begin
        score <= score + SCORE_W'(1);
      end
      if (combo != {SCORE_W{1'b1}}) begin
        combo <= combo + SCORE_W'(1);
      end
    end else if (miss_nxt) begin
      combo <= '0;
    end
  end

endmodule
